fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch controller that sits on the consumer side of the program counter. It samples the 16-bit PC and issues a read to instruction memory, then waits for the memory acknowledge and latches the returned word into the instruction register. It presents that word to decode with a valid/ready handshake and pulses PC_EN exactly once per completed fetch, so the counter advances. It is the only driver of PC_EN in the core.

## Interface
- ADDR_W, 16, PC / memory address width
- DATA_W, 32, instruction word width
- TIMEOUT, 15, max WAIT cycles before error (used only with FETCH_TIMEOUT_EN)

- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-high
- RUN  in  1  level; fetching allowed while high
- PC  in  ADDR_W  current program counter value
- PC_EN  out  1  registered one-cycle pulse, advances PC by 1
- MEM_RD  out  1  registered read request, held until acknowledged
- MEM_ADDR  out  ADDR_W  registered address, stable while MEM_RD=1
- MEM_ACK  in  1  memory acknowledge; MEM_DATA valid in the same cycle
- MEM_DATA  in  DATA_W  read data
- IR  out  DATA_W  instruction register
- IR_VALID  out  1  IR holds an unconsumed instruction
- IR_READY  in  1  decode accepts IR this cycle
- FETCH_ERR  out  1  sticky fetch timeout flag

## Operation
- The FSM has states IDLE, WAIT, HOLD and ERR. All outputs are registered.
- Values after RESET:
  - state = IDLE.
  - PC_EN, MEM_RD, IR_VALID and FETCH_ERR = 0.
  - MEM_ADDR = 0 and IR = 0.
- IDLE:
  - If RUN=1, then MEM_RD<=1, MEM_ADDR<=PC and the FSM goes to WAIT.
  - Otherwise the FSM stays in IDLE.
- WAIT:
  - MEM_RD stays at 1 and MEM_ADDR stays constant.
  - On MEM_ACK=1: IR<=MEM_DATA, IR_VALID<=1, MEM_RD<=0, PC_EN<=1 for one cycle, then go to HOLD.
  - RUN is ignored in WAIT. A started read always completes.
- HOLD:
  - IR_VALID stays at 1 and IR stays constant.
  - On IR_VALID=1 and IR_READY=1, IR_VALID<=0 and the FSM goes to IDLE.
  - IR keeps its last value after it is consumed.
- ERR: MEM_RD=0 and FETCH_ERR=1. The FSM leaves ERR only on RESET.
- MEM_ACK is ignored in IDLE, HOLD and ERR.
- PC_EN is never asserted except on the cycle after an ACK in WAIT. PC therefore equals the number of instructions fetched since reset.

## Timing
- Let edge E0 be the edge that samples MEM_ACK=1 in WAIT.
  - PC_EN is high between E0 and E1, so PC increments at E1.
  - IR and IR_VALID are visible from E0.
- The earliest handshake is at E1, giving IDLE between E1 and E2.
- At E2 the next request launches with MEM_ADDR equal to the incremented PC. Going through IDLE is mandatory: it guarantees PC is sampled after the increment.
- With zero-wait memory (ACK in the first WAIT cycle) and IR_READY tied high, throughput is one instruction per 3 cycles.
- Read latency from MEM_RD rising to IR_VALID rising is (wait cycles + 1).
- If RESET is asserted mid-operation, MEM_RD and IR_VALID drop at that edge and no PC_EN is issued. The in-flight ACK is discarded.
- If RESET and MEM_ACK occur in the same cycle, RESET wins.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ACK.
  - When the count reaches TIMEOUT with MEM_ACK=0: MEM_RD<=0, FETCH_ERR<=1, go to ERR. No PC_EN is issued and IR is unchanged.
  - If ACK arrives in the same cycle as the count reaching TIMEOUT, the ACK wins and the fetch completes normally.
- FETCH_TIMEOUT_EN undefined:
  - WAIT waits indefinitely.
  - FETCH_ERR is constant 0 and no counter logic is present.

## Test plan
- Reset state: RESET for 2 cycles, RUN=0 → all outputs 0, PC_EN stays 0 for 10 cycles.
- Zero-wait streaming: RUN=1, IR_READY=1, ACK in the first WAIT cycle, MEM_DATA=0x1000_0000+addr → MEM_ADDR sequence 0,1,2,3. IR values match. Exactly one PC_EN pulse per fetch, one fetch every 3 cycles.
- Wait states and backpressure:
  - Stimulus: ACK after 4 WAIT cycles, IR_READY low for 5 cycles after IR_VALID.
  - Required: MEM_ADDR stable through WAIT. IR and IR_VALID held through HOLD. The next MEM_RD rises 2 cycles after the handshake, with MEM_ADDR = previous + 1.
- RUN drop: deassert RUN during WAIT → the fetch completes and PC_EN pulses once, then the FSM stays in IDLE with MEM_RD=0. Reassert RUN → the request resumes at the incremented PC.
- Reset mid-fetch: RESET in WAIT, in the same cycle as MEM_ACK → no PC_EN, IR=0, IR_VALID=0, state IDLE.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT=15):
  - No ACK → at WAIT cycle 15, MEM_RD=0 and FETCH_ERR=1 (sticky), a later ACK is ignored, PC is unchanged.
  - ACK exactly at cycle 15 → the fetch completes normally with FETCH_ERR=0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: PC handshake, instruction-memory read port and decode-side IR handshake.
// master = fetch_ctrl, slave = PC / memory / decode environment.
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              RUN;
  logic [ADDR_W-1:0] PC;
  logic              PC_EN;
  logic              MEM_RD;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_ACK;
  logic [DATA_W-1:0] MEM_DATA;
  logic [DATA_W-1:0] IR;
  logic              IR_VALID;
  logic              IR_READY;
  logic              FETCH_ERR;

  modport master (
    input  RUN, PC, MEM_ACK, MEM_DATA, IR_READY,
    output PC_EN, MEM_RD, MEM_ADDR, IR, IR_VALID, FETCH_ERR
  );

  modport slave (
    output RUN, PC, MEM_ACK, MEM_DATA, IR_READY,
    input  PC_EN, MEM_RD, MEM_ADDR, IR, IR_VALID, FETCH_ERR
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: samples PC, reads instruction memory, hands IR to decode, pulses PC_EN.
// Optional FETCH_TIMEOUT_EN: WAIT bounded to TIMEOUT cycles, then sticky FETCH_ERR.
module fetch_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic         CLK,
  input  logic         RESET,
  fetch_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic              pc_en_q,    pc_en_d;
  logic              mem_rd_q,   mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q,       ir_d;
  logic              ir_valid_q, ir_valid_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_err_q, fetch_err_d;
`endif

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    pc_en_d    = 1'b0;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d       = cnt_q;
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.RUN) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = bus.PC;
          state_d    = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ST_WAIT: begin
        // A started read always completes; RUN is not looked at here
        if (bus.MEM_ACK) begin
          ir_d       = bus.MEM_DATA;
          ir_valid_d = 1'b1;
          mem_rd_d   = 1'b0;
          pc_en_d    = 1'b1;
          state_d    = ST_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_rd_d    = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_HOLD: begin
        // Returning through IDLE makes the next PC sample see the increment
        if (bus.IR_READY) begin
          ir_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_ERR: begin
        mem_rd_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        fetch_err_d = 1'b1;
`endif
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      pc_en_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_en_q    <= pc_en_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q       <= cnt_d;
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  assign bus.PC_EN    = pc_en_q;
  assign bus.MEM_RD   = mem_rd_q;
  assign bus.MEM_ADDR = mem_addr_q;
  assign bus.IR       = ir_q;
  assign bus.IR_VALID = ir_valid_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.FETCH_ERR = fetch_err_q;
`else
  assign bus.FETCH_ERR = 1'b0;
`endif

endmodule
